// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int FIFO_DATA_W = 128;
    localparam int STAT_W      = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-one finder: lowest set request at or after
// i_ptr, wrapping modulo NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_winner,
    output logic                       o_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any    = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-producer grant counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wren,
    output logic [DATA_W-1:0]          fifo_wrdata,
    input  logic                       fifo_full,
    input  logic                       fifo_alm_full,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]  stat_grants
`endif
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [GID_W-1:0]  r_grant_id;
    logic [GID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_wren;
    logic [DATA_W-1:0] r_wrdata;

    logic              w_stall;
    logic              w_owner_vld;
    logic              w_xfer;
    logic              w_release;
    logic              w_pick_any;
    logic [GID_W-1:0]  w_pick_id;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_pick_id),
        .o_any    (w_pick_any)
    );

    assign w_stall     = fifo_full | fifo_alm_full;
    assign w_owner_vld = req_valid[r_grant_id];
    assign w_xfer      = (r_state == GRANT) & w_owner_vld & ~w_stall;
    // A stalled cycle never releases, even if the owner has dropped valid.
    assign w_release   = (r_state == GRANT) & ~w_stall &
                         (~w_owner_vld | (r_beat_cnt == LAST_BEAT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_next_state = GRANT;
            GRANT:   if (w_release)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == GRANT);
        req_ready = '0;
        if ((r_state == GRANT) && !w_stall) req_ready[r_grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if ((r_state == IDLE) && w_pick_any) begin
                r_grant_id <= w_pick_id;
                r_beat_cnt <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_release)
                r_rr_ptr <= (r_grant_id == GID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
    end

    // Write strobe and data are registered: a transfer shows up one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wren   <= 1'b0;
            r_wrdata <= '0;
        end else begin
            r_wren <= w_xfer;
            if (w_xfer) r_wrdata <= req_data[int'(r_grant_id)*DATA_W +: DATA_W];
        end
    end

    assign fifo_wren   = r_wren;
    assign fifo_wrdata = r_wrdata;
    assign grant_id    = r_grant_id;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [NUM_REQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
        end else if ((r_state == IDLE) && w_pick_any) begin
            r_stat[w_pick_id] <= sat_inc(r_stat[w_pick_id]);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_grants[g*STAT_W +: STAT_W] = r_stat[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: transaction-level reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_wren;
    logic [DW-1:0]  fifo_wrdata;
    logic           fifo_full;
    logic           fifo_alm_full;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*16-1:0] stat_grants;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_wren     (fifo_wren),
        .fifo_wrdata   (fifo_wrdata),
        .fifo_full     (fifo_full),
        .fifo_alm_full (fifo_alm_full),
        .grant_id      (grant_id),
        .busy          (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_grants   (stat_grants)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, ncyc, act, exp);
        end
    endtask

    // Producers: each has a count of beats still to send and a sequence number.
    int left [N];
    int seq  [N];

    function automatic logic [DW-1:0] pdata(input int i, input int s);
        return {64'(i + 1), 64'(s + 1)};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = (left[i] > 0);
            req_data[i*DW +: DW]    = pdata(i, seq[i]);
        end
    endtask

    // Reference model: owner = -1 when nobody holds the port.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_gid   = 0;
    int            m_beats = 0;
    logic          m_wren  = 1'b0;
    logic [DW-1:0] m_wrdata = '0;
    int            m_grants [N];

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_gid    = 0;
        m_beats  = 0;
        m_wren   = 1'b0;
        m_wrdata = '0;
        for (int i = 0; i < N; i++) m_grants[i] = 0;
    endtask

    task automatic model_step(output int xid);
        bit found;
        int c;
        xid    = -1;
        m_wren = 1'b0;
        found  = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && req_valid[c]) begin
                    found   = 1;
                    m_owner = c;
                    m_gid   = c;
                    m_beats = 0;
                    if (m_grants[c] < 65535) m_grants[c]++;
                end
            end
        end else if (!(fifo_full || fifo_alm_full)) begin
            if (req_valid[m_owner]) begin
                xid      = m_owner;
                m_wren   = 1'b1;
                m_wrdata = req_data[m_owner*DW +: DW];
                m_beats++;
                if (m_beats == MB) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic cycle();
        int xid;
        @(posedge clk);
        if (rst_n) begin
            model_step(xid);
            if (xid >= 0) begin
                left[xid]--;
                seq[xid]++;
            end
        end else begin
            model_reset();
        end
        ncyc++;
        #1;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) left[i] = 0;
        fifo_full     = 1'b0;
        fifo_alm_full = 1'b0;
        drive_inputs();
        run(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_wren(input string nm, input int budget);
        int n = 0;
        while (!fifo_wren && n < budget) begin
            cycle();
            n++;
        end
        chk(nm, 128'(fifo_wren), 128'(1));
    endtask

    task automatic wait_busy(input string nm, input int budget);
        int n = 0;
        while (!busy && n < budget) begin
            cycle();
            n++;
        end
        chk(nm, 128'(busy), 128'(1));
    endtask

    // DUT-side logs of grant entries and write beats.
    int            glog [$];
    logic [DW-1:0] wlog [$];
    int            wcyc [$];
    logic          busy_q = 1'b0;
    logic [N-1:0]  exp_ready;

    always @(negedge clk) begin
        exp_ready = '0;
        if (m_owner >= 0 && !(fifo_full || fifo_alm_full)) exp_ready[m_owner] = 1'b1;
        chk("req_ready",   128'(req_ready),   128'(exp_ready));
        chk("busy",        128'(busy),        128'(m_owner >= 0));
        chk("grant_id",    128'(grant_id),    128'(m_gid));
        chk("fifo_wren",   128'(fifo_wren),   128'(m_wren));
        chk("fifo_wrdata", fifo_wrdata,       m_wrdata);
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk("stat_grants", 128'(stat_grants[i*16 +: 16]), 128'(m_grants[i]));
`endif
        if (busy && !busy_q) glog.push_back(int'(grant_id));
        busy_q = busy;
        if (fifo_wren) begin
            wlog.push_back(fifo_wrdata);
            wcyc.push_back(ncyc);
        end
    end

    initial begin
        int g0, w0, s1;
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            seq[i]  = 0;
        end
        fifo_full     = 1'b0;
        fifo_alm_full = 1'b0;
        drive_inputs();
        #2;
        chk("reset_wren",  128'(fifo_wren),   128'(0));
        chk("reset_busy",  128'(busy),        128'(0));
        chk("reset_ready", 128'(req_ready),   128'(0));
        chk("reset_gid",   128'(grant_id),    128'(0));
        chk("reset_data",  fifo_wrdata,       128'(0));
        do_reset();

        // Single producer, 6 beats: 4-beat burst, one idle cycle, then 2 beats.
        g0 = glog.size(); w0 = wlog.size();
        left[0] = 6; drive_inputs();
        run(20);
        chk("single_nwr", 128'(wlog.size() - w0), 128'(6));
        chk("single_ngr", 128'(glog.size() - g0), 128'(2));
        if (wlog.size() - w0 == 6) begin
            for (int k = 0; k < 6; k++) chk("single_data", wlog[w0+k], {64'd1, 64'(k + 1)});
            for (int k = 1; k < 6; k++)
                chk("single_gap", 128'(wcyc[w0+k] - wcyc[w0+k-1]), 128'((k == 4) ? 2 : 1));
        end
        for (int k = g0; k < glog.size(); k++) chk("single_gid", 128'(glog[k]), 128'(0));

        // Fairness: all producers valid, two bursts each.
        do_reset();
        g0 = glog.size(); w0 = wlog.size();
        for (int i = 0; i < N; i++) left[i] = 2 * MB;
        drive_inputs();
        run(60);
        chk("fair_ngr", 128'(glog.size() - g0), 128'(8));
        chk("fair_nwr", 128'(wlog.size() - w0), 128'(32));
        if (glog.size() - g0 == 8)
            for (int k = 0; k < 8; k++) chk("fair_order", 128'(glog[g0+k]), 128'(k % 4));
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("fair_stats", 128'(stat_grants[i*16 +: 16]), 128'(2));
`endif

        // Backpressure: almost-full for 5 cycles in the middle of a burst.
        do_reset();
        g0 = glog.size(); w0 = wlog.size(); s1 = seq[1];
        left[1] = MB; drive_inputs();
        wait_wren("bp_first_write", 10);
        fifo_alm_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_ready", 128'(req_ready), 128'(0));
            chk("bp_wren",  128'(fifo_wren), 128'(0));
            chk("bp_busy",  128'(busy),      128'(1));
        end
        fifo_alm_full = 1'b0;
        run(15);
        chk("bp_ngr", 128'(glog.size() - g0), 128'(1));
        chk("bp_nwr", 128'(wlog.size() - w0), 128'(MB));
        if (glog.size() - g0 == 1) chk("bp_gid", 128'(glog[g0]), 128'(1));
        if (wlog.size() - w0 == MB)
            for (int k = 0; k < MB; k++) chk("bp_data", wlog[w0+k], {64'd2, 64'(s1 + k + 1)});

        // Early release: owner 2 stops after 2 beats; 3 must win over 0.
        do_reset();
        g0 = glog.size();
        left[2] = 2; drive_inputs();
        wait_busy("early_grant", 10);
        left[0] = 3; left[3] = 3; drive_inputs();
        run(30);
        chk("early_ngr", 128'(glog.size() - g0), 128'(3));
        if (glog.size() - g0 == 3) begin
            chk("early_first",  128'(glog[g0]),   128'(2));
            chk("early_second", 128'(glog[g0+1]), 128'(3));
            chk("early_third",  128'(glog[g0+2]), 128'(0));
        end

        // Asynchronous reset while a write is in flight.
        do_reset();
        left[1] = MB; drive_inputs();
        run(3);
        left[0] = MB; drive_inputs();
        wait_wren("rst_wait_write", 12);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_wren",  128'(fifo_wren), 128'(0));
        chk("rst_async_busy",  128'(busy),      128'(0));
        chk("rst_async_ready", 128'(req_ready), 128'(0));
        model_reset();
        for (int i = 0; i < N; i++) left[i] = 0;
        drive_inputs();
        run(2);
        rst_n = 1'b1;
        g0 = glog.size();
        for (int i = 0; i < N; i++) left[i] = 1;
        drive_inputs();
        run(12);
        chk("rst_regrant_n", 128'(glog.size() - g0 >= 1), 128'(1));
        if (glog.size() > g0) chk("rst_regrant_ptr0", 128'(glog[g0]), 128'(0));

        // Randomized traffic with random full / almost-full.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (left[i] == 0 && $urandom_range(3, 0) == 0) left[i] = $urandom_range(6, 1);
            fifo_full     = ($urandom_range(9, 0) == 0);
            fifo_alm_full = ($urandom_range(5, 0) == 0);
            drive_inputs();
            cycle();
        end
        fifo_full     = 1'b0;
        fifo_alm_full = 1'b0;
        run(60);
        chk("drain_idle", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
